// File: rtl/stats_mmio_responder.sv
// Memory-mapped statistics responder: running min/max/sum/count of signed
// samples plus a multi-cycle restoring divider that produces the mean.
module stats_mmio_responder #(
   parameter logic [31:0] BASE    = 32'h0000_0100,
   parameter int          COUNT_W = 8,
   parameter int          SUM_W   = 32 + COUNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        sel
);

   localparam int STEP_W = $clog2(SUM_W + 1);
   localparam logic [COUNT_W-1:0] MAXC = {COUNT_W{1'b1}};

   typedef enum logic {IDLE, DIV} state_t;

   state_t r_state;
   state_t w_state_nx;

   logic [COUNT_W-1:0] r_count;
   logic [31:0]        r_min;
   logic [31:0]        r_max;
   logic [SUM_W-1:0]   r_sum;
   logic [31:0]        r_last;
   logic [31:0]        r_mean;
   logic               r_done;
   logic               r_err;

   logic [SUM_W-1:0]   r_quo;
   logic [COUNT_W-1:0] r_rem;
   logic [COUNT_W-1:0] r_div;
   logic               r_neg;
   logic [STEP_W-1:0]  r_step;

   logic [2:0]         w_off;
   logic               w_wr;
   logic               w_push;
   logic               w_clr;
   logic               w_start;
   logic               w_busy;
   logic               w_last;
   logic [SUM_W-1:0]   w_din_ext;
   logic [SUM_W-1:0]   w_abs;
   logic [COUNT_W:0]   w_rem_sh;
   logic               w_ge;
   logic [COUNT_W:0]   w_rem_sub;
   logic [COUNT_W-1:0] w_rem_nx;
   logic [SUM_W-1:0]   w_quo_nx;
   logic [SUM_W-1:0]   w_q_fin;

   assign sel       = (adr[31:5] == BASE[31:5]);
   assign w_off     = adr[4:2];
   assign w_wr      = we & sel;
   assign w_push    = w_wr & (w_off == 3'd0);
   assign w_clr     = w_wr & (w_off == 3'd1) & din[0];
   assign w_start   = w_wr & (w_off == 3'd1) & din[1] & ~din[0];
   assign w_busy    = (r_state == DIV);
   assign w_last    = (r_step == STEP_W'(SUM_W - 1));
   assign w_din_ext = {{(SUM_W-32){din[31]}}, din};
   assign w_abs     = r_sum[SUM_W-1] ? (~r_sum + 1'b1) : r_sum;

   // One restoring step: shift in next dividend bit, subtract if it fits.
   assign w_rem_sh  = {r_rem, r_quo[SUM_W-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_div});
   assign w_rem_sub = w_rem_sh - {1'b0, r_div};
   assign w_rem_nx  = w_ge ? w_rem_sub[COUNT_W-1:0]
                           : w_rem_sh[COUNT_W-1:0];
   assign w_quo_nx  = {r_quo[SUM_W-2:0], w_ge};
   assign w_q_fin   = r_neg ? (~w_quo_nx + 1'b1) : w_quo_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      if (w_clr) begin
         w_state_nx = IDLE;
      end else begin
         case (r_state)
            IDLE: if (w_start && r_count != '0) w_state_nx = DIV;
            DIV:  if (w_last) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset || w_clr) begin
         r_count <= '0;
         r_min   <= '0;
         r_max   <= '0;
         r_sum   <= '0;
         r_last  <= '0;
         r_mean  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_div   <= '0;
         r_neg   <= 1'b0;
         r_step  <= '0;
      end else begin
         if (w_push) begin
            if (!w_busy && r_count != MAXC) begin
               r_count <= r_count + 1'b1;
               r_sum   <= r_sum + w_din_ext;
               r_last  <= din;
               if (r_count == '0) begin
                  r_min <= din;
                  r_max <= din;
               end else begin
                  if ($signed(din) < $signed(r_min)) r_min <= din;
                  if ($signed(din) > $signed(r_max)) r_max <= din;
               end
            end else begin
               r_err <= 1'b1;
            end
         end
         if (w_start) begin
            if (w_busy) begin
               r_err <= 1'b1;
            end else if (r_count == '0) begin
               r_mean <= '0;
               r_done <= 1'b1;
            end else begin
               r_done <= 1'b0;
               r_quo  <= w_abs;
               r_rem  <= '0;
               r_div  <= r_count;
               r_neg  <= r_sum[SUM_W-1];
               r_step <= '0;
            end
         end
         if (w_busy) begin
            r_quo  <= w_quo_nx;
            r_rem  <= w_rem_nx;
            r_step <= r_step + 1'b1;
            if (w_last) begin
               r_mean <= w_q_fin[31:0];
               r_done <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      dout = '0;
      if (sel) begin
         case (w_off)
            3'd0: dout = r_last;
            3'd1: dout = '0;
            3'd2: dout = {28'd0, (r_count == '0), r_err, r_done, w_busy};
            3'd3: dout = {{(32-COUNT_W){1'b0}}, r_count};
            3'd4: dout = r_min;
            3'd5: dout = r_max;
            3'd6: dout = r_sum[31:0];
            3'd7: dout = r_mean;
            default: dout = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_stats_mmio_responder.sv
// Directed bench for stats_mmio_responder: default instance plus a
// COUNT_W=2 instance sharing the same bus stimulus.
module tb_stats_mmio_responder;

   localparam logic [31:0] B = 32'h0000_0100;
   localparam logic [31:0] A_DATA = B + 32'h00;
   localparam logic [31:0] A_CTRL = B + 32'h04;
   localparam logic [31:0] A_STAT = B + 32'h08;
   localparam logic [31:0] A_CNT  = B + 32'h0C;
   localparam logic [31:0] A_MIN  = B + 32'h10;
   localparam logic [31:0] A_MAX  = B + 32'h14;
   localparam logic [31:0] A_SUM  = B + 32'h18;
   localparam logic [31:0] A_MEAN = B + 32'h1C;

   logic        clk;
   logic        reset;
   logic        we;
   logic [31:0] adr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        sel;
   logic [31:0] dout2;
   logic        sel2;

   int checks;
   int errors;

   stats_mmio_responder #(.BASE(B)) u_dut (
      .clk(clk), .reset(reset), .we(we), .adr(adr),
      .din(din), .dout(dout), .sel(sel)
   );

   stats_mmio_responder #(.BASE(B), .COUNT_W(2), .SUM_W(34)) u_dut2 (
      .clk(clk), .reset(reset), .we(we), .adr(adr),
      .din(din), .dout(dout2), .sel(sel2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; adr = a; din = d;
      @(posedge clk);
      #1;
      we = 1'b0; adr = '0; din = '0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a,
                     input logic [31:0] exp);
      adr = a;
      #1;
      chk(tag, dout, exp);
   endtask

   task automatic rd2(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
      adr = a;
      #1;
      chk(tag, dout2, exp);
   endtask

   // Counts post-edge observations with busy=1, starting right after start.
   task automatic wait_busy(output int n);
      n = 0;
      adr = A_STAT;
      #1;
      while (dout[0] && n < 200) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   int n;

   initial begin
      checks = 0; errors = 0;
      reset = 1'b1; we = 1'b0; adr = '0; din = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      rd("rst_stat", A_STAT, 32'h8);
      rd("rst_cnt",  A_CNT,  32'h0);
      rd("rst_mean", A_MEAN, 32'h0);
      adr = 32'h0000_0200; #1;
      chk("rst_out_dout", dout, 32'h0);
      chk("rst_out_sel", {31'd0, sel}, 32'h0);

      wr(A_DATA, 32'd5);
      wr(A_DATA, 32'hFFFF_FFFD);
      wr(A_DATA, 32'd12);
      wr(A_DATA, 32'd7);
      rd("t1_cnt",  A_CNT,  32'd4);
      rd("t1_min",  A_MIN,  32'hFFFF_FFFD);
      rd("t1_max",  A_MAX,  32'd12);
      rd("t1_sum",  A_SUM,  32'd21);
      rd("t1_last", A_DATA, 32'd7);
      wr(A_CTRL, 32'h2);
      wait_busy(n);
      chk("t1_busy_len", n, 32'd40);
      rd("t1_stat", A_STAT, 32'h2);
      rd("t1_mean", A_MEAN, 32'd5);

      wr(A_CTRL, 32'h1);
      wr(A_DATA, 32'hFFFF_FFF9);
      wr(A_DATA, 32'hFFFF_FFFE);
      rd("t2_sum", A_SUM, 32'hFFFF_FFF7);
      rd("t2_min", A_MIN, 32'hFFFF_FFF9);
      wr(A_CTRL, 32'h2);
      wait_busy(n);
      chk("t2_busy_len", n, 32'd40);
      rd("t2_mean", A_MEAN, 32'hFFFF_FFFC);
      wr(A_CTRL, 32'h1);
      wr(A_DATA, 32'h8000_0000);
      wr(A_CTRL, 32'h2);
      wait_busy(n);
      rd("t2_mean_min", A_MEAN, 32'h8000_0000);

      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      wr(A_CTRL, 32'h2);
      rd("t3_stat", A_STAT, 32'hA);
      rd("t3_mean", A_MEAN, 32'h0);

      wr(A_DATA, 32'd10);
      wr(A_DATA, 32'd20);
      wr(A_CTRL, 32'h2);
      wr(A_DATA, 32'd99);
      wr(A_CTRL, 32'h2);
      rd("t4_cnt",  A_CNT,  32'd2);
      rd("t4_sum",  A_SUM,  32'd30);
      rd("t4_last", A_DATA, 32'd20);
      rd("t4_stat", A_STAT, 32'h5);
      wait_busy(n);
      chk("t4_busy_len", n, 32'd38);
      rd("t4_stat2", A_STAT, 32'h6);
      rd("t4_mean", A_MEAN, 32'd15);
      wr(A_CTRL, 32'h3);
      rd("t4_clr_cnt",  A_CNT,  32'h0);
      rd("t4_clr_sum",  A_SUM,  32'h0);
      rd("t4_clr_min",  A_MIN,  32'h0);
      rd("t4_clr_max",  A_MAX,  32'h0);
      rd("t4_clr_last", A_DATA, 32'h0);
      rd("t4_clr_mean", A_MEAN, 32'h0);
      rd("t4_clr_stat", A_STAT, 32'h8);

      wr(A_DATA, 32'd1);
      wr(A_DATA, 32'd2);
      wr(A_DATA, 32'd3);
      wr(A_DATA, 32'd4);
      rd2("t5_cnt",  A_CNT,  32'd3);
      rd2("t5_sum",  A_SUM,  32'd6);
      rd2("t5_stat", A_STAT, 32'h4);
      rd("t5_big_cnt", A_CNT, 32'd4);

      wr(A_CTRL, 32'h2);
      repeat (10) @(posedge clk);
      #2;
      rd("t5_mid_busy", A_STAT, 32'h1);
      reset = 1'b1;
      #1;
      rd("t5_rst_stat", A_STAT, 32'h8);
      rd("t5_rst_mean", A_MEAN, 32'h0);
      rd("t5_rst_cnt",  A_CNT,  32'h0);
      @(negedge clk); reset = 1'b0;

      wr(A_DATA, 32'd3);
      adr = B + 32'h20; #1;
      chk("t6_hi_sel",  {31'd0, sel}, 32'h0);
      chk("t6_hi_dout", dout, 32'h0);
      adr = B - 32'h4; #1;
      chk("t6_lo_sel",  {31'd0, sel}, 32'h0);
      chk("t6_lo_dout", dout, 32'h0);
      wr(B + 32'h20, 32'h1234);
      wr(B - 32'h4,  32'h1234);
      rd("t6_cnt",  A_CNT,  32'd1);
      rd("t6_last", A_DATA, 32'd3);
      rd("t6_ctrl", A_CTRL, 32'h0);
      adr = A_CTRL; #1;
      chk("t6_in_sel", {31'd0, sel}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
